uart_tx_pacer: RTL and testbench



---
 rtl/uart_tx_pacer.sv | 126 ++++++++++++
 tb/tb_uart_tx_pacer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_pacer.sv
// Echo-path pacer: buffers receiver bytes and hands them to the UART transmitter one frame-time apart.
// Optional CR->CRLF expansion is built when UART_TX_PACER_CRLF_EN is defined.
module uart_tx_pacer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int BAUD_CNT   = 868,
  parameter int FRAME_BITS = 11,
  parameter int GUARD      = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_flag,
  output logic [DATA_W-1:0] td_data,
  output logic              ready_flag,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam int FRAME_CYC = BAUD_CNT * FRAME_BITS + GUARD;
  localparam int TIMER_W   = $clog2(FRAME_CYC);
  // PULSE and the trailing IDLE cycle are part of the pitch, hence the -2.
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(FRAME_CYC - 2);
  localparam logic [ADDR_W:0]    FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [DATA_W-1:0]  LF_BYTE    = DATA_W'(8'h0A);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   mem_reg [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]     count_reg;
  logic [DATA_W-1:0]   td_data_reg;
  logic                ready_flag_reg, ready_flag_next;
  logic                busy_reg, busy_next;
  logic                overflow_reg;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic                fifo_full, fifo_empty, wr_accept, pop, inject_lf;

  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_empty = (count_reg == '0);
  assign wr_accept  = wr_flag && !fifo_full;

`ifdef UART_TX_PACER_CRLF_EN
  localparam logic [DATA_W-1:0] CR_BYTE = DATA_W'(8'h0D);
  // Only popped bytes can be CR, so a CR still in td_data means its LF is owed.
  assign inject_lf = (state_reg == IDLE) && (td_data_reg == CR_BYTE);
`else
  assign inject_lf = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (inject_lf || !fifo_empty) state_next = PULSE;
      PULSE:   state_next = WAIT;
      WAIT:    if (timer_reg <= TIMER_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop             = 1'b0;
    ready_flag_next = 1'b0;
    timer_next      = timer_reg;
    busy_next       = (state_next != IDLE);
    case (state_reg)
      IDLE: begin
        if (inject_lf) begin
          ready_flag_next = 1'b1;
        end else if (!fifo_empty) begin
          pop             = 1'b1;
          ready_flag_next = 1'b1;
        end
      end
      PULSE:   timer_next = TIMER_LOAD;
      WAIT:    if (timer_reg != '0) timer_next = timer_reg - 1'b1;
      default: timer_next = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (wr_accept) mem_reg[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      td_data_reg    <= '0;
      ready_flag_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      timer_reg      <= '0;
    end else begin
      ready_flag_reg <= ready_flag_next;
      busy_reg       <= busy_next;
      timer_reg      <= timer_next;
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)       rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // Full is judged on the pre-edge count, so a same-edge pop cannot rescue the write.
      if (wr_flag && fifo_full) overflow_reg <= 1'b1;
      if (pop)            td_data_reg <= mem_reg[rd_ptr_reg];
      else if (inject_lf) td_data_reg <= LF_BYTE;
    end
  end

  assign td_data    = td_data_reg;
  assign ready_flag = ready_flag_reg;
  assign busy       = busy_reg;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_tx_pacer.sv
// Bench for uart_tx_pacer with a 4-cycle bit time (46-cycle frame pitch); a scoreboard checks every start strobe.
module tb_uart_tx_pacer;

  localparam int PITCH = 46;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_flag = 1'b0;
  logic [7:0] td_data;
  logic       ready_flag;
  logic       busy;
  logic [4:0] fifo_count;
  logic       overflow;

  uart_tx_pacer #(
    .DATA_W(8), .ADDR_W(4), .BAUD_CNT(4), .FRAME_BITS(11), .GUARD(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_data(wr_data), .wr_flag(wr_flag),
    .td_data(td_data), .ready_flag(ready_flag), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         peak = 0;
  logic [7:0] sb[$];
  int         pulse_q[$];
  logic [7:0] exp_b;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("check %s: %0h ok (cycle %0d)", name, act, cyc);
    end
  endtask

  // Output monitor: every start strobe consumes one scoreboard entry.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (ready_flag) begin
        pulse_q.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: actual td_data=%02h required no pulse (cycle %0d)", td_data, cyc);
        end else begin
          exp_b = sb.pop_front();
          if (td_data !== exp_b) begin
            errors++;
            $display("FAIL pulse_data: actual=%02h required=%02h (cycle %0d)", td_data, exp_b, cyc);
          end else begin
            $display("pulse td_data=%02h ok (cycle %0d)", td_data, cyc);
          end
        end
      end
    end
  end

  task automatic do_write(input logic [7:0] d, input bit accept);
    wr_flag = 1'b1;
    wr_data = d;
    if (accept) sb.push_back(d);
    @(negedge sys_clk);
    wr_flag = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
    repeat (PITCH + 4) @(negedge sys_clk);
  endtask

  task automatic check_pulses(input string name, input int e0, input int n);
    chk({name, "_pulse_count"}, 32'(pulse_q.size()), 32'(n));
    for (int i = 0; i < pulse_q.size() && i < n; i++)
      chk({name, "_pulse_cycle"}, 32'(pulse_q[i] - e0), 32'(1 + PITCH * i));
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_busy;
    logic [4:0] exp_count;
    logic [7:0] exp_td;
  } vec_t;

  vec_t vecs[4];
  int   e0;

  initial begin
    // Per-edge behaviour of a single write into an idle, empty pacer.
    vecs[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd1, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 8'h55};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h55};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h55};

    repeat (3) @(negedge sys_clk);
    chk("rst_td_data", 32'(td_data), 32'h0);
    chk("rst_ready", 32'(ready_flag), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Single write, table-driven
    pulse_q.delete();
    e0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      wr_flag = vecs[i].wr;
      wr_data = vecs[i].data;
      if (vecs[i].wr) sb.push_back(vecs[i].data);
      @(negedge sys_clk);
      wr_flag = 1'b0;
      chk($sformatf("vec%0d_ready", i), 32'(ready_flag), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_td", i), 32'(td_data), 32'(vecs[i].exp_td));
    end
    while (cyc < e0 + 45) @(negedge sys_clk);
    chk("single_busy_late", 32'(busy), 32'h1);
    while (cyc < e0 + 47) @(negedge sys_clk);
    chk("single_busy_end", 32'(busy), 32'h0);
    chk("single_count_end", 32'(fifo_count), 32'h0);
    wait_drain(10);
    check_pulses("single", e0, 1);

    // Burst of three
    pulse_q.delete();
    peak = 0;
    e0 = cyc + 1;
    do_write(8'h11, 1'b1);
    do_write(8'h22, 1'b1);
    do_write(8'h33, 1'b1);
    wait_drain(4 * PITCH);
    check_pulses("burst", e0, 3);
    chk("burst_peak", 32'(peak), 32'd2);

    // Overflow: 18 back-to-back writes, the last one dropped
    pulse_q.delete();
    e0 = cyc + 1;
    for (int i = 0; i < 18; i++) do_write(8'(i), i < 17);
    chk("ovf_count_full", 32'(fifo_count), 32'd16);
    chk("ovf_set", 32'(overflow), 32'h1);
    wait_drain(18 * PITCH + 20);
    check_pulses("ovf", e0, 17);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // Reset mid-WAIT with five bytes queued
    pulse_q.delete();
    for (int i = 0; i < 6; i++) do_write(8'hA0 + 8'(i), 1'b1);
    repeat (10) @(negedge sys_clk);
    chk("pre_rst_count", 32'(fifo_count), 32'd5);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    sb.delete();
    chk("mid_rst_count", 32'(fifo_count), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(ready_flag), 32'h0);
    chk("mid_rst_td", 32'(td_data), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    pulse_q.delete();
    repeat (3 * PITCH) @(negedge sys_clk);
    chk("post_rst_quiet", 32'(pulse_q.size()), 32'd0);

    // CR handling
    pulse_q.delete();
    e0 = cyc + 1;
    do_write(8'h41, 1'b1);
    do_write(8'h0D, 1'b1);
`ifdef UART_TX_PACER_CRLF_EN
    sb.push_back(8'h0A);
`endif
    do_write(8'h42, 1'b1);
    wait_drain(6 * PITCH);
`ifdef UART_TX_PACER_CRLF_EN
    check_pulses("crlf", e0, 4);
`else
    check_pulses("crlf", e0, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
